// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: byte FIFO feeding an 11-bit frame serialiser
// (start 0, data LSB first, odd parity, stop 1) on registered ps2_clk/ps2_data.
module ps2_kbd_tx #(
  parameter int unsigned CLK_HALF   = 50,
  parameter int unsigned GAP        = 100,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam int unsigned MaxDiv = (CLK_HALF > GAP) ? CLK_HALF : GAP;
  localparam int unsigned CntW   = $clog2(MaxDiv) + 1;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);

  localparam logic [CntW-1:0] HalfLast = CntW'(CLK_HALF - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
  localparam logic [PtrW:0]   CountOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   CountMax = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]      LastIdx  = 4'd10;

  typedef enum logic [2:0] {StIdle, StHigh, StLow, StGap, StInhibit} state_e;

  // ---------------- byte FIFO ----------------
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            full, empty, push, pop;
  logic [7:0]      head;

  assign full     = (count_q == CountMax);
  assign empty    = (count_q == '0);
  assign tx_ready = !full && resetn;
  assign push     = tx_valid && tx_ready;
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      case ({push, pop})
        2'b10:   count_q <= count_q + CountOne;
        2'b01:   count_q <= count_q - CountOne;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- frame FSM ----------------
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      idx_next;
  logic [10:0]     sr_q, sr_d;
  logic            clk_q, clk_d;
  logic            data_q, data_d;

  assign idx_next = idx_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    clk_d   = clk_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        clk_d  = 1'b1;
        data_d = 1'b1;
        if (!empty && !ps2_inhibit) begin
          pop     = 1'b1;
          sr_d    = {1'b1, ~^head, head, 1'b0};
          idx_d   = 4'd0;
          data_d  = 1'b0;
          cnt_d   = '0;
          state_d = StHigh;
        end
      end
      StHigh, StLow: begin
        // Inhibit during the stop bit is ignored so the frame completes.
        if (ps2_inhibit && idx_q != LastIdx) begin
          clk_d   = 1'b1;
          data_d  = 1'b1;
          cnt_d   = '0;
          state_d = StInhibit;
        end else if (cnt_q != HalfLast) begin
          cnt_d = cnt_q + CntOne;
        end else if (state_q == StHigh) begin
          clk_d   = 1'b0;
          cnt_d   = '0;
          state_d = StLow;
        end else begin
          clk_d = 1'b1;
          cnt_d = '0;
          if (idx_q == LastIdx) begin
            data_d  = 1'b1;
            state_d = StGap;
          end else begin
            idx_d   = idx_next;
            data_d  = sr_q[idx_next];
            state_d = StHigh;
          end
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StInhibit: begin
        // Retained frame restarts from the start bit once inhibit has been low for GAP cycles.
        if (ps2_inhibit) begin
          cnt_d = '0;
        end else if (cnt_q == GapLast) begin
          cnt_d   = '0;
          idx_d   = 4'd0;
          data_d  = sr_q[0];
          state_d = StHigh;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        clk_d   = 1'b1;
        data_d  = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      sr_q    <= '1;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
    end
  end

  assign ps2_clk  = clk_q;
  assign ps2_data = data_q;
  assign busy     = !empty || (state_q != StIdle);

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Scoreboard bench for ps2_kbd_tx: accepted bytes queue expected frames; a host-side
// receiver model decodes ps2_clk falling-edge samples and compares against the queue.
module tb_ps2_kbd_tx;

  localparam int unsigned CLK_HALF = 4;
  localparam int unsigned GAP      = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_inhibit;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;

  ps2_kbd_tx #(
    .CLK_HALF   (CLK_HALF),
    .GAP        (GAP),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_inhibit (ps2_inhibit),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference frame: start 0, data LSB first, parity making the ones count odd, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    logic par;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  // ---------------- host-side receiver / monitor ----------------
  int          nbits = 0, since_fall = 0, high_run = 0, idle_run = 0;
  int          total_falls = 0, frames_done = 0;
  logic        prev_clk = 1'b1, prev_data = 1'b1;
  bit          had_activity = 1'b0;
  logic [10:0] got_frame;
  logic [7:0]  exp_byte;

  always @(negedge clk) begin
    if (!resetn) begin
      nbits = 0; since_fall = 0; high_run = 0; idle_run = 0;
      had_activity = 1'b0; prev_clk = 1'b1; prev_data = 1'b1;
    end else begin
      since_fall++;
      high_run = ps2_clk ? high_run + 1 : 0;
      // A long clock-high stretch mid-frame means the frame was aborted by inhibit.
      if (nbits > 0 && high_run > 2 * CLK_HALF) nbits = 0;
      if (nbits == 0 && prev_clk && ps2_clk && prev_data && !ps2_data) begin
        if (had_activity) check("inter_frame_idle", (idle_run >= GAP) ? 1 : 0, 1);
        had_activity = 1'b1;
      end
      if (prev_clk && !ps2_clk) begin
        if (nbits > 0) check("bit_spacing", since_fall, 2 * CLK_HALF);
        got_frame[nbits] = ps2_data;
        nbits++;
        since_fall = 0;
        total_falls++;
        if (nbits == 11) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", int'(got_frame), -1);
          end else begin
            exp_byte = exp_q.pop_front();
            check("frame_bits", int'(got_frame), int'(frame_of(exp_byte)));
            frames_done++;
          end
          nbits = 0;
        end
      end else if (!prev_clk && !ps2_clk) begin
        check("data_stable_while_clk_low", int'(ps2_data), int'(prev_data));
      end
      idle_run = (ps2_clk && ps2_data) ? idle_run + 1 : 0;
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send(input logic [7:0] b, output bit stalled);
    int w = 0;
    stalled  = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && w < 5000) begin
      stalled = 1'b1;
      @(negedge clk);
      w++;
    end
    if (!tx_ready) begin
      check("send_timeout", int'(tx_ready), 1);
      tx_valid = 1'b0;
    end else begin
      exp_q.push_back(b);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 5000);
    if (busy) check("wait_idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_bits(input int k);
    int w = 0;
    do begin
      @(negedge clk);
      #1;
      w++;
    end while (!(nbits == k && ps2_clk) && w < 2000);
    check("wait_bits_reached", (nbits == k && ps2_clk) ? 1 : 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit s, any_stall;
    int n, f0, falls0;

    resetn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; ps2_inhibit = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ps2_clk", int'(ps2_clk), 1);
    check("reset_ps2_data", int'(ps2_data), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_tx_ready", int'(tx_ready), 0);
    resetn = 1'b1;
    @(negedge clk);
    check("tx_ready_after_release", int'(tx_ready), 1);
    repeat (20) @(negedge clk);
    check("idle_ps2_clk", int'(ps2_clk), 1);
    check("idle_ps2_data", int'(ps2_data), 1);
    check("idle_no_falls", total_falls, 0);

    // Single byte 0x1C.
    f0 = frames_done;
    send(8'h1C, s);
    tx_valid = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    @(negedge clk);
    check("start_bit_latency", int'(ps2_data), 0);
    wait_idle(n);
    check("frame_to_idle_cycles", n, 22 * CLK_HALF + GAP);
    check("single_frame_count", frames_done - f0, 1);

    // Back-to-back 0x00, 0xFF.
    f0 = frames_done;
    send(8'h00, s);
    send(8'hFF, s);
    tx_valid = 1'b0;
    wait_idle(n);
    check("b2b_frame_count", frames_done - f0, 2);

    // Six-byte burst with valid held.
    f0 = frames_done;
    any_stall = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      send(8'(i), s);
      any_stall |= s;
    end
    tx_valid = 1'b0;
    check("burst_backpressure", int'(any_stall), 1);
    wait_idle(n);
    check("burst_frame_count", frames_done - f0, 6);
    check("burst_queue_empty", exp_q.size(), 0);

    // Inhibit during data bit 3 of 0x5A.
    f0 = frames_done;
    falls0 = total_falls;
    send(8'h5A, s);
    tx_valid = 1'b0;
    wait_bits(4);
    ps2_inhibit = 1'b1;
    @(negedge clk);
    check("abort_clk_high", int'(ps2_clk), 1);
    check("abort_data_high", int'(ps2_data), 1);
    n = total_falls;
    repeat (30) @(negedge clk);
    check("no_falls_while_inhibited", total_falls - n, 0);
    ps2_inhibit = 1'b0;
    n = 0;
    while (ps2_data && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("restart_latency", n, GAP);
    wait_idle(n);
    check("inhibit_frame_count", frames_done - f0, 1);
    check("inhibit_total_falls", total_falls - falls0, 4 + 11);

    // Inhibit during the stop bit is ignored.
    f0 = frames_done;
    falls0 = total_falls;
    send(8'hA5, s);
    tx_valid = 1'b0;
    wait_bits(10);
    ps2_inhibit = 1'b1;
    repeat (12) @(negedge clk);
    ps2_inhibit = 1'b0;
    wait_idle(n);
    check("stop_inhibit_frame_count", frames_done - f0, 1);
    check("stop_inhibit_falls", total_falls - falls0, 11);

    // Reset at bit 5 with two bytes queued.
    send(8'h11, s);
    send(8'h22, s);
    send(8'h33, s);
    tx_valid = 1'b0;
    wait_bits(5);
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midreset_clk_high", int'(ps2_clk), 1);
    check("midreset_data_high", int'(ps2_data), 1);
    check("midreset_busy", int'(busy), 0);
    check("midreset_tx_ready", int'(tx_ready), 0);
    resetn = 1'b1;
    falls0 = total_falls;
    repeat (200) @(negedge clk);
    check("midreset_no_frames", total_falls - falls0, 0);
    check("midreset_idle", int'(busy), 0);

    // Randomised bytes with random inhibit pulses.
    f0 = frames_done;
    fork
      begin
        bit rs;
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 30)) @(negedge clk);
          send(8'($urandom_range(0, 255)), rs);
          tx_valid = 1'b0;
        end
      end
      begin
        for (int j = 0; j < 6; j++) begin
          repeat ($urandom_range(20, 150)) @(negedge clk);
          ps2_inhibit = 1'b1;
          repeat ($urandom_range(1, 20)) @(negedge clk);
          ps2_inhibit = 1'b0;
        end
      end
    join
    wait_idle(n);
    check("random_frame_count", frames_done - f0, 12);
    check("random_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
